hub_capture_rx: RTL

- Downstream stage of the transient signal capture block; plays the HUB role on the TRD/SBF/SD/CD link.
- On TRD it issues an SBF request, then deserialises the SD bit stream into a local byte buffer until CD rises.
- Exposes the buffer, byte count and status to the host side through a registered read port and a done/ack handshake.

---
 rtl/hub_capture_rx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hub_capture_rx.sv
// HUB side of the TRD/SBF/SD/CD capture link: requests the buffer, deserialises
// SD frames into a local byte store and hands the result to the host with done/ack.
module hub_capture_rx #(
  parameter int DEPTH     = 32,
  parameter int SBF_PULSE = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       trd,
  input  logic                       sd,
  input  logic                       cd,
  output logic                       sbf,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [7:0]                 rd_data,
  output logic [$clog2(DEPTH):0]     byte_count,
  output logic                       done,
  input  logic                       ack,
  output logic                       timeout_err,
  output logic                       frame_err,
  output logic                       overflow,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SBF_PULSE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SBF_LAST = SW'(SBF_PULSE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_CD, HUNT, DATA, DONE} state_t;

  state_t          state, state_d;
  logic [SW-1:0]   sbf_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [2:0]      bit_cnt;
  logic [6:0]      shift;
  logic [AW-1:0]   wr_ptr;
  logic [7:0]      mem [DEPTH];

  logic            start, byte_end, wr_en;
  logic [7:0]      wr_byte;

  // Status outputs decode straight from state so reset clears them with no clock.
  assign sbf  = (state == REQ);
  assign done = (state == DONE);
  assign busy = (state != IDLE) && (state != DONE);

  assign start    = (state == IDLE) && trd && enable;
  assign byte_end = (state == DATA) && !cd && (bit_cnt == 3'd7);
  assign wr_en    = byte_end && (byte_count < DEPTH_C);
  // Bits arrive LSB first; the 8th bit is still on sd when the byte completes.
  assign wr_byte  = {sd, shift};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (sbf_cnt == SBF_LAST) state_d = WAIT_CD;
      WAIT_CD: if (!cd) state_d = HUNT;
               else if (tmo_cnt == TMO_LAST) state_d = DONE;
      HUNT:    if (cd) state_d = DONE;
               else if (!sd) state_d = DATA;
      DATA:    if (cd) state_d = DONE;
               else if (bit_cnt == 3'd7) state_d = HUNT;
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sbf_cnt     <= '0;
      tmo_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      wr_ptr      <= '0;
      byte_count  <= '0;
      timeout_err <= 1'b0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (start) begin
        sbf_cnt     <= '0;
        tmo_cnt     <= '0;
        wr_ptr      <= '0;
        byte_count  <= '0;
        timeout_err <= 1'b0;
        frame_err   <= 1'b0;
        overflow    <= 1'b0;
      end
      if (state == REQ) sbf_cnt <= sbf_cnt + 1'b1;
      // Timeout window opens at SBF assertion, so REQ cycles count too.
      if (state == REQ || state == WAIT_CD) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == WAIT_CD && cd && tmo_cnt == TMO_LAST) timeout_err <= 1'b1;
      if (state == HUNT && !cd && !sd) bit_cnt <= '0;
      if (state == DATA) begin
        if (cd) frame_err <= 1'b1;
        else begin
          shift   <= {sd, shift[6:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (wr_en) begin
        wr_ptr     <= wr_ptr + 1'b1;
        byte_count <= byte_count + 1'b1;
      end else if (byte_end) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule
